// File: rtl/fg_input_conditioner.sv
// Multi-channel pad input conditioner: per-channel synchronizer, consecutive-sample
// debounce filter, and registered rise/fall strobes in the clk_i domain.
module fg_input_conditioner #(
  parameter int                  CHANNELS      = 4,
  parameter int                  STAGES        = 2,
  parameter int                  FILTER_CYCLES = 4,
  parameter logic [CHANNELS-1:0] RESET_VAL     = '0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [CHANNELS-1:0] async_i,
  output logic [CHANNELS-1:0] level_o,
  output logic [CHANNELS-1:0] rise_o,
  output logic [CHANNELS-1:0] fall_o,
  output logic                any_edge_o
);

  localparam int               CNT_W   = $clog2(FILTER_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_CYCLES - 1);

  logic [CHANNELS-1:0] w_level;
  logic [CHANNELS-1:0] w_rise_nxt;
  logic [CHANNELS-1:0] w_fall_nxt;
  logic [CHANNELS-1:0] r_rise;
  logic [CHANNELS-1:0] r_fall;
  logic                r_any;

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    logic [STAGES-1:0] r_sync;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_level;
    logic              w_syn;
    logic              w_differ;
    logic              w_done;

    // Bit 0 is the only flop allowed to go metastable; only bit 1 reads it.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        r_sync <= {STAGES{RESET_VAL[ch]}};
      end else begin
        r_sync <= {r_sync[STAGES-2:0], async_i[ch]};
      end
    end

    assign w_syn = r_sync[STAGES-1];

    always_comb begin
      w_differ = (w_syn != r_level);
      w_done   = w_differ && (r_cnt == CNT_MAX);
    end

    // Any sample matching the current level restarts the count.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        r_cnt   <= '0;
        r_level <= RESET_VAL[ch];
      end else if (!w_differ || w_done) begin
        r_cnt <= '0;
        if (w_done) begin
          r_level <= w_syn;
        end
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end

    assign w_level[ch]    = r_level;
    assign w_rise_nxt[ch] = w_done & w_syn;
    assign w_fall_nxt[ch] = w_done & ~w_syn;
  end

  // Strobes register alongside the level so they coincide with its first visible cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rise <= '0;
      r_fall <= '0;
      r_any  <= 1'b0;
    end else begin
      r_rise <= w_rise_nxt;
      r_fall <= w_fall_nxt;
      r_any  <= |(w_rise_nxt | w_fall_nxt);
    end
  end

  assign level_o    = w_level;
  assign rise_o     = r_rise;
  assign fall_o     = r_fall;
  assign any_edge_o = r_any;

endmodule

// File: tb/tb_fg_input_conditioner.sv
// Directed bench for fg_input_conditioner: default build, RESET_VAL=4'b1010 build
// and FILTER_CYCLES=1 build, sharing one clock and reset.
module tb_fg_input_conditioner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] a_def = 4'b0000;
  logic [3:0] a_rv  = 4'b1010;
  logic [3:0] a_f1  = 4'b0000;

  logic [3:0] lvl_def, rise_def, fall_def;
  logic       any_def;
  logic [3:0] lvl_rv, rise_rv, fall_rv;
  logic       any_rv;
  logic [3:0] lvl_f1, rise_f1, fall_f1;
  logic       any_f1;

  int n_pass  = 0;
  int n_total = 0;
  int rv_strobes = 0;

  fg_input_conditioner dut (
    .clk_i(clk), .rst_i(rst), .async_i(a_def),
    .level_o(lvl_def), .rise_o(rise_def), .fall_o(fall_def), .any_edge_o(any_def)
  );

  fg_input_conditioner #(.RESET_VAL(4'b1010)) dut_rv (
    .clk_i(clk), .rst_i(rst), .async_i(a_rv),
    .level_o(lvl_rv), .rise_o(rise_rv), .fall_o(fall_rv), .any_edge_o(any_rv)
  );

  fg_input_conditioner #(.FILTER_CYCLES(1)) dut_f1 (
    .clk_i(clk), .rst_i(rst), .async_i(a_f1),
    .level_o(lvl_f1), .rise_o(rise_f1), .fall_o(fall_f1), .any_edge_o(any_f1)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rise_rv != 4'b0 || fall_rv != 4'b0 || any_rv) rv_strobes++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; a_def = 4'b0000; a_rv = 4'b1010; a_f1 = 4'b0000;
    repeat (3) tick();
    n_total++;
    if ({lvl_def, rise_def, fall_def, any_def} !== 13'b0) begin
      $display("FAIL reset_def: got lvl=%b rise=%b fall=%b any=%b, expected all 0",
               lvl_def, rise_def, fall_def, any_def);
    end else n_pass++;
    n_total++;
    if ({lvl_rv, rise_rv, fall_rv, any_rv} !== {4'b1010, 9'b0}) begin
      $display("FAIL reset_rv: got lvl=%b rise=%b fall=%b any=%b, expected lvl=1010 no strobes",
               lvl_rv, rise_rv, fall_rv, any_rv);
    end else n_pass++;
    rst = 1'b0;
    for (int k = 0; k < 50; k++) begin
      tick();
      n_total++;
      if ({lvl_def, rise_def, fall_def, any_def, lvl_rv, rise_rv, fall_rv, any_rv}
          !== {13'b0, 4'b1010, 9'b0}) begin
        $display("FAIL post_reset k=%0d: got def lvl=%b r=%b f=%b a=%b rv lvl=%b r=%b f=%b a=%b, expected def 0, rv lvl=1010 quiet",
                 k, lvl_def, rise_def, fall_def, any_def, lvl_rv, rise_rv, fall_rv, any_rv);
      end else n_pass++;
    end
  endtask

  task automatic test_rise();
    logic [3:0] e_lvl, e_rise;
    logic       e_any;
    for (int k = 0; k < 8; k++) begin
      if (k == 0) a_def = 4'b0001;
      tick();
      e_lvl  = (k >= 5) ? 4'b0001 : 4'b0000;
      e_rise = (k == 5) ? 4'b0001 : 4'b0000;
      e_any  = (k == 5);
      n_total++;
      if ({lvl_def, rise_def, fall_def, any_def} !== {e_lvl, e_rise, 4'b0000, e_any}) begin
        $display("FAIL rise k=%0d: got lvl=%b rise=%b fall=%b any=%b, expected lvl=%b rise=%b fall=0000 any=%b",
                 k, lvl_def, rise_def, fall_def, any_def, e_lvl, e_rise, e_any);
      end else n_pass++;
    end
    a_def = 4'b0000;
    repeat (12) tick();
  endtask

  task automatic test_glitch();
    logic [3:0] e_lvl, e_rise, e_fall;
    logic       e_any;
    for (int k = 0; k < 12; k++) begin
      if (k == 0) a_def = 4'b0010;
      if (k == 3) a_def = 4'b0000;
      tick();
      n_total++;
      if ({lvl_def, rise_def, fall_def, any_def} !== 13'b0) begin
        $display("FAIL glitch3 k=%0d: got lvl=%b rise=%b fall=%b any=%b, expected all 0",
                 k, lvl_def, rise_def, fall_def, any_def);
      end else n_pass++;
    end
    for (int k = 0; k < 14; k++) begin
      if (k == 0) a_def = 4'b0010;
      if (k == 4) a_def = 4'b0000;
      tick();
      e_lvl  = (k >= 5 && k < 9) ? 4'b0010 : 4'b0000;
      e_rise = (k == 5) ? 4'b0010 : 4'b0000;
      e_fall = (k == 9) ? 4'b0010 : 4'b0000;
      e_any  = (k == 5 || k == 9);
      n_total++;
      if ({lvl_def, rise_def, fall_def, any_def} !== {e_lvl, e_rise, e_fall, e_any}) begin
        $display("FAIL glitch4 k=%0d: got lvl=%b rise=%b fall=%b any=%b, expected lvl=%b rise=%b fall=%b any=%b",
                 k, lvl_def, rise_def, fall_def, any_def, e_lvl, e_rise, e_fall, e_any);
      end else n_pass++;
    end
  endtask

  task automatic test_bounce();
    logic [3:0] e_lvl, e_rise;
    logic       e_any;
    for (int k = 0; k < 28; k++) begin
      if (k == 0) a_def = 4'b0100;
      if (k == 3) a_def = 4'b0000;
      if (k == 4) a_def = 4'b0100;
      tick();
      e_lvl  = (k >= 9) ? 4'b0100 : 4'b0000;
      e_rise = (k == 9) ? 4'b0100 : 4'b0000;
      e_any  = (k == 9);
      n_total++;
      if ({lvl_def, rise_def, fall_def, any_def} !== {e_lvl, e_rise, 4'b0000, e_any}) begin
        $display("FAIL bounce k=%0d: got lvl=%b rise=%b fall=%b any=%b, expected lvl=%b rise=%b fall=0000 any=%b",
                 k, lvl_def, rise_def, fall_def, any_def, e_lvl, e_rise, e_any);
      end else n_pass++;
    end
    a_def = 4'b0000;
    repeat (12) tick();
    n_total++;
    if (lvl_def !== 4'b0000) begin
      $display("FAIL bounce_settle: got lvl=%b, expected 0000", lvl_def);
    end else n_pass++;
  endtask

  task automatic test_simultaneous();
    logic [3:0] e_lvl, e_rise, e_fall;
    logic       e_any;
    for (int k = 0; k < 17; k++) begin
      if (k == 0) a_def = 4'b1111;
      if (k == 9) a_def = 4'b0000;
      tick();
      e_lvl  = (k >= 5 && k < 14) ? 4'b1111 : 4'b0000;
      e_rise = (k == 5) ? 4'b1111 : 4'b0000;
      e_fall = (k == 14) ? 4'b1111 : 4'b0000;
      e_any  = (k == 5 || k == 14);
      n_total++;
      if ({lvl_def, rise_def, fall_def, any_def} !== {e_lvl, e_rise, e_fall, e_any}) begin
        $display("FAIL simultaneous k=%0d: got lvl=%b rise=%b fall=%b any=%b, expected lvl=%b rise=%b fall=%b any=%b",
                 k, lvl_def, rise_def, fall_def, any_def, e_lvl, e_rise, e_fall, e_any);
      end else n_pass++;
    end
  endtask

  task automatic test_filter1();
    logic [3:0] e_lvl, e_rise, e_fall;
    for (int k = 0; k < 10; k++) begin
      if (k == 0) a_f1 = 4'b0001;
      if (k == 5) a_f1 = 4'b0000;
      tick();
      e_lvl  = (k >= 2 && k < 7) ? 4'b0001 : 4'b0000;
      e_rise = (k == 2) ? 4'b0001 : 4'b0000;
      e_fall = (k == 7) ? 4'b0001 : 4'b0000;
      n_total++;
      if ({lvl_f1, rise_f1, fall_f1, any_f1} !== {e_lvl, e_rise, e_fall, (k == 2 || k == 7)}) begin
        $display("FAIL filter1 k=%0d: got lvl=%b rise=%b fall=%b any=%b, expected lvl=%b rise=%b fall=%b",
                 k, lvl_f1, rise_f1, fall_f1, any_f1, e_lvl, e_rise, e_fall);
      end else n_pass++;
    end
  endtask

  task automatic test_reset_clears_strobe();
    a_def = 4'b0001;
    repeat (6) tick();
    n_total++;
    if ({rise_def, any_def} !== 5'b0001_1) begin
      $display("FAIL pre_reset_strobe: got rise=%b any=%b, expected rise=0001 any=1", rise_def, any_def);
    end else n_pass++;
    #1 rst = 1'b1;
    #1;
    n_total++;
    if ({lvl_def, rise_def, fall_def, any_def} !== 13'b0) begin
      $display("FAIL reset_clears: got lvl=%b rise=%b fall=%b any=%b, expected all 0",
               lvl_def, rise_def, fall_def, any_def);
    end else n_pass++;
    a_def = 4'b0000;
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset_midcount();
    logic [3:0] e_lvl, e_rise;
    a_def = 4'b1000;
    repeat (4) tick();
    rst = 1'b1;
    #1;
    n_total++;
    if ({lvl_def, rise_def, any_def} !== 9'b0) begin
      $display("FAIL midcount_reset: got lvl=%b rise=%b any=%b, expected all 0", lvl_def, rise_def, any_def);
    end else n_pass++;
    repeat (2) tick();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      e_lvl  = (k >= 5) ? 4'b1000 : 4'b0000;
      e_rise = (k == 5) ? 4'b1000 : 4'b0000;
      n_total++;
      if ({lvl_def, rise_def, fall_def, any_def} !== {e_lvl, e_rise, 4'b0000, (k == 5)}) begin
        $display("FAIL midcount_restart k=%0d: got lvl=%b rise=%b fall=%b any=%b, expected lvl=%b rise=%b",
                 k, lvl_def, rise_def, fall_def, any_def, e_lvl, e_rise);
      end else n_pass++;
    end
    a_def = 4'b0000;
    repeat (12) tick();
  endtask

  task automatic test_rv_quiet();
    n_total++;
    if (rv_strobes != 0 || lvl_rv !== 4'b1010) begin
      $display("FAIL rv_quiet: got strobe_cycles=%0d lvl=%b, expected 0 and 1010", rv_strobes, lvl_rv);
    end else n_pass++;
  endtask

  initial begin
    test_reset();
    test_rise();
    test_glitch();
    test_bounce();
    test_simultaneous();
    test_filter1();
    test_reset_clears_strobe();
    test_reset_midcount();
    test_rv_quiet();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
